csr_unit: RTL and testbench

Parametrised machine-mode CSR unit for the decode/execute boundary. It supports the CSRRW/CSRRS/CSRRC read-modify-write operations and detects illegal accesses. It also sequences trap entry and MRET updates to mstatus/mepc/mcause, tracks interrupt pending/enable, and runs the mcycle/minstret performance counters.

---
 rtl/csr_unit_if.sv | 21 ++
 rtl/csr_unit.sv | 203 ++++++++++++++++++++
 tb/tb_csr_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_unit_if.sv
// CSR access bus between the decode/execute stage (master) and csr_unit (slave).
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_valid_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_address_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;

  modport master (
    output csr_valid_i, csr_op_i, csr_address_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_valid_i, csr_op_i, csr_address_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSRRW/RS/RC, illegal-access detection, trap/MRET sequencing, interrupts.
// Optional feature macro: CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters.
module csr_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [XLEN-1:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_unit_if.slave       csr,
  input  logic            instret_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            ext_irq_i,
  input  logic            timer_irq_i,
  output logic            irq_pending_o,
  output logic [XLEN-1:0] trap_vector_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  csr_op_e         op;
  logic [11:0]     addr;
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mip_q;
  logic [XLEN-1:0] mstatus_view, mip_sample;
  logic [XLEN-1:0] rdata_q;
  logic            illegal_q;
  logic [XLEN-1:0] old_val, new_val;
  logic            addr_known, addr_ro, wr_intent, illegal;
  logic            csr_req, csr_accept, do_write;
  logic [XLEN-1:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
  logic [XLEN-1:0] tvec_base;

  assign op   = csr_op_e'(csr.csr_op_i);
  assign addr = csr.csr_address_i;

  // Traps and MRET pre-empt a CSR op in the same cycle; the op is dropped outright.
  assign csr_req    = csr.csr_valid_i && (op != OP_NONE);
  assign csr_accept = csr_req && !trap_valid_i && !mret_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    mstatus_view    = '0;
    mstatus_view[3] = mstatus_mie_q;
    mstatus_view[7] = mstatus_mpie_q;
    mip_sample      = '0;
    mip_sample[11]  = ext_irq_i;
    mip_sample[7]   = timer_irq_i;
  end

  always_comb begin
    old_val    = '0;
    addr_known = 1'b1;
    case (addr)
      ADDR_MSTATUS:   old_val = mstatus_view;
      ADDR_MISA:      old_val = MISA_VALUE;
      ADDR_MIE:       old_val = mie_q;
      ADDR_MTVEC:     old_val = mtvec_q;
      ADDR_MSCRATCH:  old_val = mscratch_q;
      ADDR_MEPC:      old_val = mepc_q;
      ADDR_MCAUSE:    old_val = mcause_q;
      ADDR_MIP:       old_val = mip_q;
      ADDR_MHARTID:   old_val = HART_ID;
      ADDR_MCYCLE:    old_val = mcycle_lo;
      ADDR_MCYCLEH:   old_val = mcycle_hi;
      ADDR_MINSTRET:  old_val = minstret_lo;
      ADDR_MINSTRETH: old_val = minstret_hi;
      default:        addr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and never writes, so it is legal on read-only CSRs.
  assign addr_ro   = (addr[11:10] == 2'b11) || (addr == ADDR_MISA);
  assign wr_intent = (op == OP_RW) || (|csr.csr_wdata_i);
  assign illegal   = !addr_known || (addr_ro && wr_intent);
  assign do_write  = csr_accept && wr_intent && !illegal;

  always_comb begin
    new_val = csr.csr_wdata_i;
    case (op)
      OP_RS:   new_val = old_val | csr.csr_wdata_i;
      OP_RC:   new_val = old_val & ~csr.csr_wdata_i;
      default: new_val = csr.csr_wdata_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and the asynchronous reset sits in the sensitivity list.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mip_q          <= '0;
      rdata_q        <= '0;
      illegal_q      <= 1'b0;
    end else begin
      mip_q <= mip_sample;
      if (trap_valid_i) begin
        mepc_q         <= {trap_pc_i[XLEN-1:2], 2'b00};
        mcause_q       <= trap_cause_i;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (do_write) begin
        case (addr)
          ADDR_MSTATUS: begin
            mstatus_mie_q  <= new_val[3];
            mstatus_mpie_q <= new_val[7];
          end
          ADDR_MIE:      mie_q      <= new_val;
          ADDR_MTVEC:    mtvec_q    <= {new_val[XLEN-1:2], 1'b0, new_val[0]};
          ADDR_MSCRATCH: mscratch_q <= new_val;
          ADDR_MEPC:     mepc_q     <= {new_val[XLEN-1:2], 2'b00};
          ADDR_MCAUSE:   mcause_q   <= new_val;
          default: ;
        endcase
      end

      if (csr_accept) begin
        rdata_q   <= illegal ? '0 : old_val;
        illegal_q <= illegal;
      end else if (csr_req) begin
        illegal_q <= 1'b0;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // A write to either half replaces that half and suppresses this cycle's increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (do_write && addr == ADDR_MCYCLE)        mcycle_q[31:0]  <= new_val;
      else if (do_write && addr == ADDR_MCYCLEH)  mcycle_q[63:32] <= new_val;
      else                                        mcycle_q        <= mcycle_q + 64'd1;

      if (do_write && addr == ADDR_MINSTRET)      minstret_q[31:0]  <= new_val;
      else if (do_write && addr == ADDR_MINSTRETH) minstret_q[63:32] <= new_val;
      else if (instret_i)                         minstret_q        <= minstret_q + 64'd1;
    end
  end

  assign mcycle_lo   = mcycle_q[31:0];
  assign mcycle_hi   = mcycle_q[63:32];
  assign minstret_lo = minstret_q[31:0];
  assign minstret_hi = minstret_q[63:32];
`else
  logic unused_instret;
  assign unused_instret = instret_i;
  assign mcycle_lo      = '0;
  assign mcycle_hi      = '0;
  assign minstret_lo    = '0;
  assign minstret_hi    = '0;
`endif

  // Vectored mode applies only to interrupts; exceptions always land on the base.
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  always_comb begin
    trap_vector_o = tvec_base;
    if (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1])
      trap_vector_o = tvec_base + {trap_cause_i[XLEN-3:0], 2'b00};
  end

  assign irq_pending_o     = mstatus_mie_q && (|(mip_q & mie_q));
  assign mepc_o            = mepc_q;
  assign csr.csr_rdata_o   = rdata_q;
  assign csr.csr_illegal_o = illegal_q;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed scenarios plus randomized traffic against a CSR-map reference model.
module tb_csr_unit;
  localparam int          XLEN      = 32;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;
  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
  localparam logic [31:0] HART      = 32'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instret_i, trap_valid_i, mret_i, ext_irq_i, timer_irq_i;
  logic [31:0] trap_cause_i, trap_pc_i;
  logic        irq_pending_o;
  logic [31:0] trap_vector_o, mepc_o;

  csr_unit_if #(.XLEN(XLEN)) bus ();

  csr_unit #(
    .XLEN(XLEN), .MTVEC_RESET(MTVEC_RST), .MISA_VALUE(MISA_VAL), .HART_ID(HART)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr(bus),
    .instret_i(instret_i), .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .mret_i(mret_i), .ext_irq_i(ext_irq_i), .timer_irq_i(timer_irq_i),
    .irq_pending_o(irq_pending_o), .trap_vector_o(trap_vector_o), .mepc_o(mepc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: the CSR file as an address-keyed map plus two 64-bit counters.
  bit [31:0] m_csr [bit [11:0]];
  bit [63:0] m_cyc, m_ret;
  bit [31:0] m_rdata;
  bit        m_ill;

  function automatic void model_reset();
    m_csr.delete();
    m_csr[12'h300] = 0; m_csr[12'h304] = 0; m_csr[12'h305] = MTVEC_RST;
    m_csr[12'h340] = 0; m_csr[12'h341] = 0; m_csr[12'h342] = 0; m_csr[12'h344] = 0;
    m_cyc = 0; m_ret = 0; m_rdata = 0; m_ill = 0;
  endfunction

  function automatic bit m_known(input bit [11:0] a);
    return m_csr.exists(a) || a == 12'h301 || a == 12'hF14 ||
           a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82;
  endfunction

  function automatic bit [31:0] m_read(input bit [11:0] a);
    case (a)
      12'h301: return MISA_VAL;
      12'hF14: return HART;
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
`endif
      default: return m_csr.exists(a) ? m_csr[a] : 32'h0;
    endcase
  endfunction

  function automatic void m_step();
    bit [31:0] nxt [bit [11:0]];
    bit [63:0] cyc_n, ret_n;
    bit [31:0] ms, old, nv, wd;
    bit [11:0] a;
    bit [1:0]  op;
    bit        req, ro, wants, bad;
    nxt   = m_csr;
    cyc_n = m_cyc + 1;
    ret_n = m_ret + (instret_i ? 64'd1 : 64'd0);
    ms    = m_csr[12'h300];
    nxt[12'h344] = (ext_irq_i ? 32'h800 : 32'h0) | (timer_irq_i ? 32'h80 : 32'h0);
    a  = bus.csr_address_i;
    op = bus.csr_op_i;
    wd = bus.csr_wdata_i;
    req = bus.csr_valid_i && op != 2'b00;
    if (trap_valid_i) begin
      nxt[12'h341] = trap_pc_i & ~32'h3;
      nxt[12'h342] = trap_cause_i;
      nxt[12'h300] = ms[3] ? 32'h80 : 32'h0;
      if (req) m_ill = 0;
    end else if (mret_i) begin
      nxt[12'h300] = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
      if (req) m_ill = 0;
    end else if (req) begin
      old   = m_read(a);
      ro    = (a[11:10] == 2'b11) || a == 12'h301;
      wants = (op == 2'b01) || wd != 0;
      bad   = !m_known(a) || (ro && wants);
      m_ill   = bad;
      m_rdata = bad ? 32'h0 : old;
      if (!bad && wants) begin
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        case (a)
          12'h300: nxt[a] = nv & 32'h88;
          12'h305: nxt[a] = nv & ~32'h2;
          12'h341: nxt[a] = nv & ~32'h3;
          12'h304, 12'h340, 12'h342: nxt[a] = nv;
`ifdef CSR_COUNTERS_EN
          12'hB00: cyc_n = {m_cyc[63:32], nv};
          12'hB80: cyc_n = {nv, m_cyc[31:0]};
          12'hB02: ret_n = {m_ret[63:32], nv};
          12'hB82: ret_n = {nv, m_ret[31:0]};
`endif
          default: ;
        endcase
      end
    end
    m_csr = nxt;
    m_cyc = cyc_n;
    m_ret = ret_n;
  endfunction

  function automatic bit [31:0] m_vector();
    bit [31:0] tv, base;
    tv   = m_csr[12'h305];
    base = tv & ~32'h3;
    if (tv[1:0] == 2'b01 && trap_cause_i[31]) return base + 4 * (trap_cause_i & 32'h7FFF_FFFF);
    return base;
  endfunction

  function automatic bit m_pending();
    bit [31:0] ms;
    ms = m_csr[12'h300];
    return ms[3] && ((m_csr[12'h344] & m_csr[12'h304]) != 0);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".rdata"},   bus.csr_rdata_o,   m_rdata);
    check({tag, ".illegal"}, bus.csr_illegal_o, m_ill);
    check({tag, ".pending"}, irq_pending_o,     m_pending());
    check({tag, ".mepc"},    mepc_o,            m_csr[12'h341]);
    check({tag, ".vector"},  trap_vector_o,     m_vector());
  endtask

  task automatic tick(input string tag);
    m_step();
    @(posedge clk_i);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    bus.csr_valid_i = 0; bus.csr_op_i = 0; bus.csr_address_i = 0; bus.csr_wdata_i = 0;
    instret_i = 0; trap_valid_i = 0; mret_i = 0;
  endtask

  task automatic csr_op(input string tag, input bit [1:0] op, input bit [11:0] a, input bit [31:0] wd);
    bus.csr_valid_i = 1; bus.csr_op_i = op; bus.csr_address_i = a; bus.csr_wdata_i = wd;
    tick(tag);
    bus.csr_valid_i = 0; bus.csr_op_i = 0;
  endtask

  localparam bit [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;
  bit [11:0] pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                           12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0,
                           12'h123, 12'hF11};

  initial begin
    int pulses;
    rst_i = 1;
    idle_inputs();
    ext_irq_i = 0; timer_irq_i = 0; trap_cause_i = 0; trap_pc_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    compare_all("reset");
    check("reset.rdata", bus.csr_rdata_o, 0);
    check("reset.pending", irq_pending_o, 0);
    check("reset.vector", trap_vector_o, MTVEC_RST);

    // Read-modify-write sequence on mscratch.
    csr_op("rw340", RW, 12'h340, 32'hDEADBEEF); check("rw340.old", bus.csr_rdata_o, 32'h0);
    csr_op("rs340", RS, 12'h340, 32'h10);       check("rs340.old", bus.csr_rdata_o, 32'hDEADBEEF);
    csr_op("rc340", RC, 12'h340, 32'hFFFF0000); check("rc340.old", bus.csr_rdata_o, 32'hDEADBEFF);
    csr_op("rd340", RS, 12'h340, 32'h0);        check("rd340.val", bus.csr_rdata_o, 32'h0000BEFF);

    // Illegal accesses.
    csr_op("rwF14", RW, 12'hF14, 32'd5);
    check("rwF14.ill", bus.csr_illegal_o, 1); check("rwF14.rdata", bus.csr_rdata_o, 0);
    csr_op("rsF14", RS, 12'hF14, 32'd0);
    check("rsF14.ill", bus.csr_illegal_o, 0); check("rsF14.rdata", bus.csr_rdata_o, HART);
    csr_op("rd7C0", RS, 12'h7C0, 32'd0);       check("rd7C0.ill", bus.csr_illegal_o, 1);

    // Interrupt pending, trap entry and MRET.
    csr_op("mstatus", RW, 12'h300, 32'h8);
    csr_op("mie", RW, 12'h304, 32'h800);
    ext_irq_i = 1;
    #1 check("irq.before", irq_pending_o, 0);
    tick("irq1");
    tick("irq2");
    check("irq.pending", irq_pending_o, 1);
    trap_valid_i = 1; trap_cause_i = 32'h8000_000B; trap_pc_i = 32'h100;
    tick("trap");
    trap_valid_i = 0; ext_irq_i = 0;
    check("trap.mepc", mepc_o, 32'h100); check("trap.pending", irq_pending_o, 0);
    csr_op("trap.ms", RS, 12'h300, 0);     check("trap.mstatus", bus.csr_rdata_o, 32'h80);
    mret_i = 1; tick("mret"); mret_i = 0;
    csr_op("mret.ms", RS, 12'h300, 0);     check("mret.mstatus", bus.csr_rdata_o, 32'h88);

    // Vectored trap target.
    csr_op("mtvec", RW, 12'h305, 32'h1001);
    trap_cause_i = 32'h8000_0007;
    #1 check("vec.irq", trap_vector_o, 32'h101C);
    trap_cause_i = 32'h2;
    #1 check("vec.exc", trap_vector_o, 32'h1000);
    trap_cause_i = 0;

    // Trap pre-empts a same-cycle CSR write.
    csr_op("scr", RW, 12'h340, 32'hAAAA5555);
    csr_op("misa.rw", RW, 12'h301, 32'h1); check("misa.ill", bus.csr_illegal_o, 1);
    bus.csr_valid_i = 1; bus.csr_op_i = RW; bus.csr_address_i = 12'h340; bus.csr_wdata_i = 32'h1234;
    trap_valid_i = 1; trap_cause_i = 32'h2; trap_pc_i = 32'h200;
    tick("trap+rw");
    idle_inputs(); trap_cause_i = 0;
    check("trap+rw.ill", bus.csr_illegal_o, 0); check("trap+rw.rdata", bus.csr_rdata_o, 0);
    check("trap+rw.mepc", mepc_o, 32'h200);
    csr_op("trap+rw.scr", RS, 12'h340, 0);  check("trap+rw.mscratch", bus.csr_rdata_o, 32'hAAAA5555);

    // Reset during a pending write.
    bus.csr_valid_i = 1; bus.csr_op_i = RW; bus.csr_address_i = 12'h340; bus.csr_wdata_i = 32'h1234;
    #2 rst_i = 1;
    idle_inputs();
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 0;
    compare_all("rst_mid");
    csr_op("rst_mid.scr", RS, 12'h340, 0);   check("rst_mid.mscratch", bus.csr_rdata_o, 0);
    csr_op("rst_mid.mtvec", RS, 12'h305, 0); check("rst_mid.mtvec_v", bus.csr_rdata_o, MTVEC_RST);

`ifdef CSR_COUNTERS_EN
    csr_op("cyc.lo", RW, 12'hB00, 32'hFFFF_FFFF);
    csr_op("cyc.hi", RW, 12'hB80, 32'hFFFF_FFFF);
    tick("cyc.wrap");
    csr_op("cyc.rdhi", RS, 12'hB80, 0); check("cyc.hi_after_wrap", bus.csr_rdata_o, 0);
    csr_op("cyc.rdlo", RS, 12'hB00, 0); check("cyc.lo_counting", bus.csr_rdata_o, 1);
    csr_op("ret.lo", RW, 12'hB02, 0);
    csr_op("ret.hi", RW, 12'hB82, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      instret_i = $urandom_range(0, 1);
      if (instret_i) pulses++;
      tick("ret.pulse");
    end
    instret_i = 0;
    csr_op("ret.rd", RS, 12'hB02, 0); check("ret.count", bus.csr_rdata_o, pulses);
`else
    csr_op("cnt.rw", RW, 12'hB00, 32'h1234);
    check("cnt.rdata", bus.csr_rdata_o, 0); check("cnt.ill", bus.csr_illegal_o, 0);
    csr_op("cnt.rd", RS, 12'hB82, 0);        check("cnt.rd0", bus.csr_rdata_o, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.csr_valid_i   = $urandom_range(0, 3) != 0;
      bus.csr_op_i      = 2'($urandom_range(0, 3));
      bus.csr_address_i = pool[$urandom_range(0, 15)];
      bus.csr_wdata_i   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      instret_i         = $urandom_range(0, 1);
      trap_valid_i      = $urandom_range(0, 15) == 0;
      mret_i            = $urandom_range(0, 15) == 0;
      ext_irq_i         = $urandom_range(0, 1);
      timer_irq_i       = $urandom_range(0, 1);
      trap_cause_i      = {1'($urandom_range(0, 1)), 26'd0, 5'($urandom_range(0, 31))};
      trap_pc_i         = $urandom & ~32'h3;
      tick("rand");
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
